// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and baud constants for the 8N1 UART receiver.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int unsigned CLK_FREQ_HZ          = 100_000_000;
  localparam int unsigned BAUD                 = 9600;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = CLK_FREQ_HZ / BAUD;

  // Counter value at which the start bit is checked (mid start bit).
  function automatic logic [31:0] half_period_last(input int unsigned cpb);
    return 32'(cpb / 2 - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_8n1_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_8n1_if
// Brief    : Serial line and received-byte strobes between pin, receiver, decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_8n1_if #(
  parameter int unsigned DATA_BITS = 8
);

  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  rx,
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchroniser for a single asynchronous input bit.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  wire  clk_in,
  input  wire  rst,
  input  wire  i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_8n1.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_8n1
// Brief    : 8N1 UART receiver, mid-bit sampling, valid and framing-error strobes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned DATA_BITS    = 8
) (
  input  wire             clk_in,
  input  wire             rst,
  uart_rx_8n1_if.master   bus
);

  localparam logic [31:0]         c_half_last = half_period_last(CLKS_PER_BIT);
  localparam logic [31:0]         c_bit_last  = 32'(CLKS_PER_BIT - 1);
  localparam int unsigned         c_idx_w     = $clog2(DATA_BITS + 1);
  localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx_8n1: CLKS_PER_BIT must be at least 4");
  end

  state_t               r_state;
  state_t               w_state_next;
  logic [31:0]          r_cnt;
  logic [c_idx_w-1:0]   r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;

  logic w_rx_s;
  logic w_half_hit;
  logic w_bit_hit;
  logic w_busy;
  logic w_data_tick;
  logic w_stop_tick;
  logic w_valid_set;
  logic w_ferr_set;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .i_d    (bus.rx),
    .o_q    (w_rx_s)
  );

  assign w_half_hit = (r_cnt == c_half_last);
  assign w_bit_hit  = (r_cnt == c_bit_last);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (!w_rx_s) w_state_next = START;
      end
      START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (w_half_hit) w_state_next = w_rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (w_bit_hit && (r_bit_idx == c_idx_last)) w_state_next = STOP;
      end
      STOP: begin
        if (w_bit_hit) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy      = (r_state != IDLE);
    w_data_tick = 1'b0;
    w_stop_tick = 1'b0;
    case (r_state)
      DATA:    w_data_tick = w_bit_hit;
      STOP:    w_stop_tick = w_bit_hit;
      default: ;
    endcase
    w_valid_set = w_stop_tick & w_rx_s;
    w_ferr_set  = w_stop_tick & ~w_rx_s;
  end

  // Restarting the count after each data sample keeps samples one bit apart.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if ((w_state_next != r_state) || w_data_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end

      if (r_state != DATA) begin
        r_bit_idx <= '0;
      end else if (w_data_tick) begin
        r_bit_idx <= r_bit_idx + 1'b1;
      end

      if (w_data_tick) begin
        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
      end

      if (w_valid_set) begin
        r_rx_data <= r_shift;
      end

      r_rx_valid  <= w_valid_set;
      r_frame_err <= w_ferr_set;
    end
  end

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_8n1.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_8n1
// Brief    : Self-checking bench for uart_rx_8n1 at 16 clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_8n1;

  localparam int CPB    = 16;
  localparam int T_BIT  = 160;   // ideal bit period in time units (clock = 10)

  typedef struct {
    bit         err;
    logic [7:0] data;
  } evt_t;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         period;
    bit         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  logic clk_in;
  logic rst;
  int   checks;
  int   errors;
  int   both_cnt;
  evt_t obs_q[$];
  evt_t exp_q[$];
  vec_t vecs[8];

  uart_rx_8n1_if #(.DATA_BITS(8)) bus ();

  uart_rx_8n1 #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus.master)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Record every strobe with the byte presented alongside it.
  always @(negedge clk_in) begin
    if (bus.rx_valid && bus.frame_err) both_cnt++;
    if (bus.rx_valid || bus.frame_err)
      obs_q.push_back('{err: bus.frame_err, data: bus.rx_data});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Line transitions are kept off clock edges (2 units past a negedge).
  task automatic align();
    @(negedge clk_in);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int period);
    bus.rx = 1'b0;
    #(period);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      #(period);
    end
    bus.rx = stop_ok;
    #(period);
    bus.rx = 1'b1;
  endtask

  initial begin
    int         lat;
    int         nv;
    int         low;
    int         bcnt;
    int         per;
    int         gap;
    bit         bad;
    logic [7:0] d;
    logic [7:0] last_good;

    checks   = 0;
    errors   = 0;
    both_cnt = 0;
    rst      = 1'b1;
    bus.rx   = 1'b1;

    vecs[0] = '{8'h3C, 1'b1, 160, 1'b0, 8'h3C};
    vecs[1] = '{8'h55, 1'b0, 160, 1'b1, 8'h3C};
    vecs[2] = '{8'h96, 1'b1, 155, 1'b0, 8'h96};
    vecs[3] = '{8'h96, 1'b1, 165, 1'b0, 8'h96};
    vecs[4] = '{8'h00, 1'b1, 160, 1'b0, 8'h00};
    vecs[5] = '{8'hFF, 1'b0, 160, 1'b1, 8'h00};
    vecs[6] = '{8'h81, 1'b1, 165, 1'b0, 8'h81};
    vecs[7] = '{8'h7E, 1'b1, 155, 1'b0, 8'h7E};

    // Reset state
    repeat (3) @(negedge clk_in);
    check("rst_rx_data", 32'(bus.rx_data), 32'h0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
    check("rst_frame_err", 32'(bus.frame_err), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk_in);

    // 0xA5 with latency measurement from the start edge
    obs_q.delete();
    align();
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, T_BIT);
      begin
        for (int c = 1; c <= 400 && lat == 0; c++) begin
          @(posedge clk_in);
          @(negedge clk_in);
          if (bus.rx_valid) lat = c;
        end
      end
    join
    #(3 * T_BIT);
    check_range("a5_latency", lat, 2 + CPB / 2 + 9 * CPB, 2 + CPB / 2 + 9 * CPB + 2);
    check("a5_count", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) begin
      check("a5_data", 32'(obs_q[0].data), 32'hA5);
      check("a5_err", 32'(obs_q[0].err), 32'h0);
    end

    // Table of single frames, each followed by idle line
    for (int i = 0; i < 8; i++) begin
      obs_q.delete();
      align();
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].period);
      #(3 * T_BIT);
      check($sformatf("vec%0d_count", i), 32'(obs_q.size()), 32'd1);
      if (obs_q.size() > 0) begin
        check($sformatf("vec%0d_err", i), 32'(obs_q[0].err), 32'(vecs[i].exp_err));
        check($sformatf("vec%0d_data", i), 32'(obs_q[0].data), 32'(vecs[i].exp_data));
      end
    end

    // Back-to-back 0x3C, 0xFF with a single stop bit
    obs_q.delete();
    align();
    nv  = 0;
    low = 0;
    fork
      begin
        send_frame(8'h3C, 1'b1, T_BIT);
        send_frame(8'hFF, 1'b1, T_BIT);
      end
      begin
        for (int c = 0; c < 600 && nv < 2; c++) begin
          @(negedge clk_in);
          if (bus.rx_valid) nv++;
          else if (nv == 1 && !bus.busy) low++;
        end
      end
    join
    #(3 * T_BIT);
    check("b2b_pulses", 32'(nv), 32'd2);
    check_range("b2b_busy_low", low, 1, 8);
    check("b2b_count", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) begin
      check("b2b_first", 32'(obs_q[0].data), 32'h3C);
      check("b2b_second", 32'(obs_q[1].data), 32'hFF);
    end

    // 4-cycle low glitch on an idle line
    obs_q.delete();
    align();
    bus.rx = 1'b0;
    #40;
    bus.rx = 1'b1;
    bcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_in);
      if (bus.busy) bcnt++;
    end
    check_range("glitch_busy", bcnt, 6, 10);
    check("glitch_events", 32'(obs_q.size()), 32'd0);

    // Reset during data bit 4 of 0x81, then a clean 0x81
    obs_q.delete();
    align();
    d = 8'h81;
    bus.rx = 1'b0;
    #(T_BIT);
    for (int i = 0; i < 4; i++) begin
      bus.rx = d[i];
      #(T_BIT);
    end
    bus.rx = d[4];
    #(T_BIT / 2);
    rst = 1'b1;
    #1;
    check("midrst_rx_data", 32'(bus.rx_data), 32'h0);
    check("midrst_rx_valid", 32'(bus.rx_valid), 32'h0);
    check("midrst_frame_err", 32'(bus.frame_err), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    bus.rx = 1'b1;
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    #(6 * T_BIT);
    check("midrst_no_partial", 32'(obs_q.size()), 32'd0);
    align();
    send_frame(8'h81, 1'b1, T_BIT);
    #(3 * T_BIT);
    check("midrst_resend_count", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) begin
      check("midrst_resend_data", 32'(obs_q[0].data), 32'h81);
      check("midrst_resend_err", 32'(obs_q[0].err), 32'h0);
    end

    // Random frames against a frame-level model
    obs_q.delete();
    exp_q.delete();
    last_good = 8'h81;
    align();
    for (int n = 0; n < 16; n++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      if (bad) begin
        per = T_BIT;
        gap = 2 + $urandom_range(0, 2);
        exp_q.push_back('{err: 1'b1, data: last_good});
      end else begin
        case ($urandom_range(0, 2))
          0:       per = 155;
          1:       per = 160;
          default: per = 165;
        endcase
        gap = $urandom_range(0, 3);
        exp_q.push_back('{err: 1'b0, data: d});
        last_good = d;
      end
      send_frame(d, !bad, per);
      #(gap * per);
    end
    #(3 * T_BIT);
    check("rand_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("rand%0d_err", i), 32'(obs_q[i].err), 32'(exp_q[i].err));
      check($sformatf("rand%0d_data", i), 32'(obs_q[i].data), 32'(exp_q[i].data));
    end

    check("no_dual_strobe", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
